// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, instruction
// classes and default sizing/hold constants.
package instr_sequencer_pkg;

    localparam int DEF_INSTR_WIDTH    = 20;
    localparam int DEF_PROG_ADDR_BITS = 5;
    localparam int DEF_HOLD_ALU       = 3;
    localparam int DEF_HOLD_LD        = 4;
    localparam int DEF_HOLD_ST        = 3;
    localparam int CNT_W              = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DONE  = 2'b11
    } seq_state_t;

    typedef enum logic [1:0] {
        CLS_HALT = 2'b00,
        CLS_ALU  = 2'b01,
        CLS_LD   = 2'b10,
        CLS_ST   = 2'b11
    } instr_class_t;

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: synchronous write port, asynchronous read port.
// Contents are deliberately not reset so a program survives a sequencer abort.
module prog_mem
    import instr_sequencer_pkg::*;
#(
    parameter int WIDTH     = DEF_INSTR_WIDTH,
    parameter int ADDR_BITS = DEF_PROG_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Steps through the program memory, holding each instruction on the CPU port for
// a class-dependent number of cycles with a zero-word gap between instructions.
//
// state | meaning
// IDLE  | waiting for start; program memory writable
// FETCH | read mem[pc], decode class (instruction is 0 this cycle)
// HOLD  | drive fetched word while the hold counter runs down to 0
// DONE  | one-cycle done pulse, then back to IDLE
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int INSTR_WIDTH    = DEF_INSTR_WIDTH,
    parameter int PROG_ADDR_BITS = DEF_PROG_ADDR_BITS,
    parameter int HOLD_ALU       = DEF_HOLD_ALU,
    parameter int HOLD_LD        = DEF_HOLD_LD,
    parameter int HOLD_ST        = DEF_HOLD_ST
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      prog_we,
    input  logic [PROG_ADDR_BITS-1:0] prog_addr,
    input  logic [INSTR_WIDTH-1:0]    prog_data,
    output logic [INSTR_WIDTH-1:0]    instruction,
    output logic [PROG_ADDR_BITS-1:0] pc,
    output logic                      issue,
    output logic                      busy,
    output logic                      done
);

    seq_state_t             state;
    logic [CNT_W-1:0]       cnt;
    logic [INSTR_WIDTH-1:0] rd_word;
    instr_class_t           rd_class;
    logic                   mem_we;

    // Reset outranks a pending write so an aborting host cannot corrupt the program.
    assign mem_we   = prog_we && !busy && !rst;
    assign rd_class = instr_class_t'(rd_word[INSTR_WIDTH-1:INSTR_WIDTH-2]);

    prog_mem #(
        .WIDTH     (INSTR_WIDTH),
        .ADDR_BITS (PROG_ADDR_BITS)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (rd_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= '0;
            cnt         <= '0;
            instruction <= '0;
            issue       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            issue <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_FETCH;
                        pc    <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (rd_class == CLS_HALT) begin
                        state       <= ST_DONE;
                        instruction <= '0;
                        done        <= 1'b1;
                    end else begin
                        state       <= ST_HOLD;
                        instruction <= rd_word;
                        issue       <= 1'b1;
                        case (rd_class)
                            CLS_ALU: cnt <= CNT_W'(HOLD_ALU - 1);
                            CLS_LD:  cnt <= CNT_W'(HOLD_LD - 1);
                            default: cnt <= CNT_W'(HOLD_ST - 1);
                        endcase
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        instruction <= '0;
                        if (pc == '1) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            pc    <= pc + 1'b1;
                            state <= ST_FETCH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter INSTR_WIDTH, default 20: instruction word width.
REQ-002 SHALL have parameter PROG_ADDR_BITS, default 5: program memory depth of 32 words.
REQ-003 SHALL have parameter HOLD_ALU, default 3: cycles an ALU instruction (class 2'b01) is held.
REQ-004 SHALL have parameter HOLD_LD, default 4: cycles a LOAD_R instruction (class 2'b10) is held.
REQ-005 SHALL have parameter HOLD_ST, default 3: cycles a STORE_R instruction (class 2'b11) is held.
REQ-006 SHALL have port clk, input, 1: single system clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: begin program execution at address 0.
REQ-009 SHALL have port prog_we, input, 1: program memory write enable.
REQ-010 SHALL have port prog_addr, input, PROG_ADDR_BITS: program write address.
REQ-011 SHALL have port prog_data, input, INSTR_WIDTH: program write data.
REQ-012 SHALL have port instruction, output, INSTR_WIDTH: word driven to the simple_cpu instruction port.
REQ-013 SHALL have port pc, output, PROG_ADDR_BITS: address of the current or next instruction.
REQ-014 SHALL have port issue, output, 1: one-cycle pulse in the first cycle a new instruction is driven.
REQ-015 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-016 SHALL have port done, output, 1: one-cycle completion pulse.

Function
REQ-017 SHALL contain a 2^PROG_ADDR_BITS x INSTR_WIDTH program memory with synchronous write and asynchronous read.
REQ-018 SHALL accept a write when prog_we=1 and busy=0; prog_we SHALL be ignored while busy=1.
REQ-019 SHALL implement an FSM with states IDLE, FETCH, HOLD and DONE.
REQ-020 SHALL go from IDLE to FETCH on start=1 and set pc=0; start SHALL be ignored outside IDLE.
REQ-021 In FETCH, SHALL register mem[pc] into the instruction register on the exiting edge.
REQ-022 In FETCH, if the class bits [INSTR_WIDTH-1:INSTR_WIDTH-2] are 2'b00, SHALL treat the word as HALT, go to DONE and keep instruction at 0.
REQ-023 In FETCH, for any other class, SHALL go to HOLD and load the hold counter with HOLD_x-1 for that class.
REQ-024 SHALL drive instruction with the fetched word for exactly HOLD_x consecutive HOLD cycles; issue SHALL be high in the first of these cycles only.
REQ-025 In HOLD, SHALL decrement the counter; at counter=0 it SHALL leave HOLD.
REQ-026 On leaving HOLD with pc = all-ones, SHALL go to DONE (end-of-memory, no wrap).
REQ-027 On leaving HOLD otherwise, SHALL increment pc and go to FETCH.
REQ-028 In DONE, SHALL assert done=1 for one cycle, then return to IDLE; pc SHALL keep its last value.
REQ-029 instruction SHALL be 0 in IDLE, FETCH and DONE; FETCH therefore gives one zero-word gap between instructions.
REQ-030 Per-instruction cost SHALL be 1 + HOLD_x cycles.
REQ-031 A write and start in the same IDLE cycle SHALL both take effect: the write commits, and FETCH on the next cycle reads the new word.

Reset
REQ-032 On rst=1, SHALL force state to IDLE, pc to 0, counter to 0, instruction to 0, and issue, busy and done to 0, at the next edge.
REQ-033 rst SHALL take priority over start and prog_we; rst during HOLD SHALL abort the program with no done pulse.
REQ-034 Program memory contents SHALL NOT be cleared by rst.

Structure
REQ-035 The shared package SHALL hold the state encoding (IDLE, FETCH, HOLD, DONE), the class codes (HALT 00, ALU 01, LD 10, ST 11) and the default width and hold constants.
REQ-036 The program memory SHALL be one sub-module, prog_mem, with a write port and an asynchronous read port; the FSM, pc and counter SHALL live in instr_sequencer.

Verification
REQ-037 Load ADD 20'h47000 at address 0 and HALT at address 1, then pulse start -> instruction=20'h47000 for 3 cycles with issue in the first, then done one cycle later, then busy=0.
REQ-038 Program ADD, SUB 20'h72001, STORE_R 20'hD80F0, LOAD_R 20'hB80F0, HALT -> hold lengths 3/3/3/4 with one zero-gap cycle between each; pc steps 0,1,2,3,4; exactly one done pulse.
REQ-039 Fill all 32 words with ALU instructions -> 32 issue pulses, done after pc=31, pc stays 31, no wrap to 0.
REQ-040 Assert rst during the second HOLD cycle of an instruction -> next cycle IDLE, instruction=0, pc=0, no done pulse; a later start replays the unchanged program.
REQ-041 Pulse prog_we and start while busy -> memory unchanged and execution unaffected.
REQ-042 Program word 0 as HALT, then start -> busy for two cycles (FETCH, DONE), done pulse, no issue pulse, instruction stays 0.
